// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared types and constants for the hazard controller
package hazard_controller_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Operand source for EX: the younger producer (EX/MEM) wins over the older one
   function automatic logic [1:0] fwd_select(input logic ex_hit, input logic mem_hit);
      if (ex_hit)
         return FWD_EXMEM;
      else if (mem_hit)
         return FWD_MEMWB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - ID-stage request and pipeline control bundle
interface hazard_controller_if
   import hazard_controller_pkg::*;
#(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [REG_W-1:0] id_rn;
   logic             id_rn_used;
   logic [REG_W-1:0] id_rm;
   logic             id_rm_used;
   logic [REG_W-1:0] id_rd;
   logic             id_reg_write;
   logic             id_is_load;
   logic             ex_branch_taken;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rn, id_rn_used, id_rm, id_rm_used, id_rd,
             id_reg_write, id_is_load, ex_branch_taken,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_count
   );

   modport slave (
      input  id_valid, id_rn, id_rn_used, id_rm, id_rm_used, id_rd,
             id_reg_write, id_is_load, ex_branch_taken,
      output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, stall_count
   );

endinterface

// File: rtl/hazard_shadow_stage.sv
// rtl/hazard_shadow_stage.sv - one shadow pipeline entry {valid, rd, is_load} with source match
module hazard_shadow_stage
   import hazard_controller_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [REG_W-1:0] in_rd,
   input  logic             in_is_load,
   input  logic [REG_W-1:0] src_a,
   input  logic             src_a_used,
   input  logic [REG_W-1:0] src_b,
   input  logic             src_b_used,
   output logic             valid,
   output logic [REG_W-1:0] rd,
   output logic             is_load,
   output logic             match_a,
   output logic             match_b
);

   // Entry advances unconditionally every cycle; reset empties it
   always_ff @(posedge clock) begin
      if (!reset) begin
         valid   <= 1'b0;
         rd      <= '0;
         is_load <= 1'b0;
      end else begin
         valid   <= in_valid;
         rd      <= in_rd;
         is_load <= in_is_load;
      end
   end

   // XZR is never a real dependency, so it can never match
   always_comb begin
      match_a = valid && src_a_used && (src_a == rd) && (src_a != ZERO_REG);
      match_b = valid && src_b_used && (src_b == rd) && (src_b != ZERO_REG);
   end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline issue/stall/flush controller (optional HAZARD_FWD_EN)
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 32
)(
   input logic               clock,
   input logic               reset,
   hazard_controller_if.slave bus
);

   localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

   state_t            state;
   state_t            state_next;
   logic [BOOT_W-1:0] boot_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic              run;
   logic              stall;
   logic              issue;
   logic              pc_write;
   logic              ifid_write;
   logic              ifid_flush;
   logic              idex_bubble;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;

   logic             ex_valid,  mem_valid,  wb_valid;
   logic [REG_W-1:0] ex_rd,     mem_rd,     wb_rd;
   logic             ex_is_load, mem_is_load, wb_is_load;
   logic             ex_match_a, ex_match_b;
   logic             mem_match_a, mem_match_b;
   logic             wb_match_a, wb_match_b;
   logic             unused_sigs;

   assign run = reset && (state == ST_RUN);

   hazard_shadow_stage u_ex (
      .clock(clock), .reset(reset),
      .in_valid(issue), .in_rd(bus.id_rd), .in_is_load(bus.id_is_load),
      .src_a(bus.id_rn), .src_a_used(bus.id_rn_used),
      .src_b(bus.id_rm), .src_b_used(bus.id_rm_used),
      .valid(ex_valid), .rd(ex_rd), .is_load(ex_is_load),
      .match_a(ex_match_a), .match_b(ex_match_b)
   );

   hazard_shadow_stage u_mem (
      .clock(clock), .reset(reset),
      .in_valid(ex_valid), .in_rd(ex_rd), .in_is_load(ex_is_load),
      .src_a(bus.id_rn), .src_a_used(bus.id_rn_used),
      .src_b(bus.id_rm), .src_b_used(bus.id_rm_used),
      .valid(mem_valid), .rd(mem_rd), .is_load(mem_is_load),
      .match_a(mem_match_a), .match_b(mem_match_b)
   );

   // WB entry is kept for visibility only: the write-first regfile hides it
   hazard_shadow_stage u_wb (
      .clock(clock), .reset(reset),
      .in_valid(mem_valid), .in_rd(mem_rd), .in_is_load(mem_is_load),
      .src_a(bus.id_rn), .src_a_used(bus.id_rn_used),
      .src_b(bus.id_rm), .src_b_used(bus.id_rm_used),
      .valid(wb_valid), .rd(wb_rd), .is_load(wb_is_load),
      .match_a(wb_match_a), .match_b(wb_match_b)
   );

   assign unused_sigs = ^{wb_valid, wb_rd, wb_is_load, wb_match_a, wb_match_b, ex_is_load};

`ifdef HAZARD_FWD_EN
   // Only a load still in EX cannot be forwarded in time
   assign stall = run && bus.id_valid && ex_is_load && (ex_match_a || ex_match_b);
`else
   // Without bypass paths the consumer waits until the producer reaches WB
   assign stall = run && bus.id_valid &&
                  (ex_match_a || ex_match_b || mem_match_a || mem_match_b);
`endif

   assign issue = run && bus.id_valid && bus.id_reg_write && (bus.id_rd != ZERO_REG) &&
                  !stall && !bus.ex_branch_taken;

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= ST_BOOT;
      else        state <= state_next;
   end

   // Next state: leave BOOT after the last boot cycle
   always_comb begin
      state_next = state;
      if (state == ST_BOOT && boot_cnt == BOOT_LAST)
         state_next = ST_RUN;
   end

   // Pipeline controls: boot/reset hold, then branch > stall > issue
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (run) begin
         if (bus.ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
         end else begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
         end
      end
   end

   // Boot counter runs only while in BOOT
   always_ff @(posedge clock) begin
      if (!reset)                 boot_cnt <= '0;
      else if (state == ST_BOOT)  boot_cnt <= boot_cnt + 1'b1;
   end

   // Saturating stall counter; a branch-cancelled stall is not counted
   always_ff @(posedge clock) begin
      if (!reset)
         stall_cnt <= '0;
      else if (stall && !bus.ex_branch_taken && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end

`ifdef HAZARD_FWD_EN
   // Forward selects follow the instruction into EX; bubbles carry regfile selects
   always_ff @(posedge clock) begin
      if (!reset || idex_bubble || !bus.id_valid) begin
         fwd_a <= FWD_REG;
         fwd_b <= FWD_REG;
      end else begin
         fwd_a <= fwd_select(ex_match_a, mem_match_a);
         fwd_b <= fwd_select(ex_match_b, mem_match_b);
      end
   end
`else
   assign fwd_a = FWD_REG;
   assign fwd_b = FWD_REG;
`endif

   assign bus.pc_write    = pc_write;
   assign bus.ifid_write  = ifid_write;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.fwd_a       = fwd_a;
   assign bus.fwd_b       = fwd_b;
   assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;

   hazard_controller_if #(.CNT_W(32)) bus ();

   hazard_controller #(.BOOT_CYCLES(2), .CNT_W(32)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   logic [3:0] ctrl;
   assign ctrl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble};

   localparam logic [3:0] C_HOLD   = 4'b0011;
   localparam logic [3:0] C_ISSUE  = 4'b1100;
   localparam logic [3:0] C_STALL  = 4'b0001;
   localparam logic [3:0] C_BRANCH = 4'b1111;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rn, input logic rn_u,
                           input logic [4:0] rm, input logic rm_u, input logic [4:0] rd,
                           input logic wr, input logic ld);
      bus.id_valid     = v;
      bus.id_rn        = rn;
      bus.id_rn_used   = rn_u;
      bus.id_rm        = rm;
      bus.id_rm_used   = rm_u;
      bus.id_rd        = rd;
      bus.id_reg_write = wr;
      bus.id_is_load   = ld;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_drain();
      drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      repeat (3) step();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b0;
      bus.ex_branch_taken = 1'b0;
      drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

      // Reset held for two edges, then two boot cycles
      @(negedge clock);
      expect_eq("reset_ctrl", ctrl, C_HOLD);
      expect_eq("reset_cnt", bus.stall_count, 0);
      expect_eq("reset_fwd", {bus.fwd_a, bus.fwd_b}, 4'b0000);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      expect_eq("boot0_ctrl", ctrl, C_HOLD);
      step();
      @(negedge clock);
      expect_eq("boot1_ctrl", ctrl, C_HOLD);
      step();
      @(negedge clock);
      expect_eq("run_ctrl", ctrl, C_ISSUE);
      expect_eq("run_cnt", bus.stall_count, 0);

      // Independent stream: ADD X2,X16,X18 ; ORR X3,X16,X18
      drive_id(1'b1, 5'd16, 1'b1, 5'd18, 1'b1, 5'd2, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("indep_add", ctrl, C_ISSUE);
      step();
      drive_id(1'b1, 5'd16, 1'b1, 5'd18, 1'b1, 5'd3, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("indep_orr", ctrl, C_ISSUE);
      step();
      idle_drain();

`ifndef HAZARD_FWD_EN
      // RAW without forwarding: ADD X2,X16,X18 ; SUB X4,X2,X18 -> two stalls
      drive_id(1'b1, 5'd16, 1'b1, 5'd18, 1'b1, 5'd2, 1'b1, 1'b0);
      step();
      drive_id(1'b1, 5'd2, 1'b1, 5'd18, 1'b1, 5'd4, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("raw_stall1", ctrl, C_STALL);
      step();
      @(negedge clock);
      expect_eq("raw_stall2", ctrl, C_STALL);
      step();
      @(negedge clock);
      expect_eq("raw_issue", ctrl, C_ISSUE);
      expect_eq("raw_cnt", bus.stall_count, 2);
      step();
      @(negedge clock);
      expect_eq("raw_fwd_const", {bus.fwd_a, bus.fwd_b}, 4'b0000);
      idle_drain();
`else
      // ALU forwarding: ADD X2,X16,X18 ; EOR X7,X2,X2 -> no stall, both from EX/MEM
      drive_id(1'b1, 5'd16, 1'b1, 5'd18, 1'b1, 5'd2, 1'b1, 1'b0);
      step();
      drive_id(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("fwd_alu_issue", ctrl, C_ISSUE);
      step();
      drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      expect_eq("fwd_alu_sel", {bus.fwd_a, bus.fwd_b}, 4'b0101);
      expect_eq("fwd_alu_cnt", bus.stall_count, 0);
      idle_drain();

      // Load-use: LDUR X2,[X16,#0] ; ADD X6,X2,X18 -> one stall, then fwd_a from MEM/WB
      drive_id(1'b1, 5'd16, 1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1);
      step();
      drive_id(1'b1, 5'd2, 1'b1, 5'd18, 1'b1, 5'd6, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("ldu_stall", ctrl, C_STALL);
      step();
      @(negedge clock);
      expect_eq("ldu_issue", ctrl, C_ISSUE);
      expect_eq("ldu_cnt", bus.stall_count, 1);
      step();
      drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(negedge clock);
      expect_eq("ldu_fwd", {bus.fwd_a, bus.fwd_b}, 4'b1000);
      idle_drain();
`endif

      // XZR: ADD X31,X16,X18 ; AND X5,X31,X18 -> no stall
      drive_id(1'b1, 5'd16, 1'b1, 5'd18, 1'b1, 5'd31, 1'b1, 1'b0);
      step();
      drive_id(1'b1, 5'd31, 1'b1, 5'd18, 1'b1, 5'd5, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("xzr_no_stall", ctrl, C_ISSUE);
      step();
      idle_drain();

      // Invalid ID slot naming a busy register never stalls
      drive_id(1'b1, 5'd16, 1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1);
      step();
      drive_id(1'b0, 5'd2, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("invalid_no_stall", ctrl, C_ISSUE);
      step();
      idle_drain();

      // Branch overrides a pending stall: LDUR X2 ; SUB X4,X2,X18 stalled ; branch
`ifdef HAZARD_FWD_EN
      expect_eq("br_pre_cnt", bus.stall_count, 1);
`else
      expect_eq("br_pre_cnt", bus.stall_count, 2);
`endif
      drive_id(1'b1, 5'd16, 1'b1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1);
      step();
      drive_id(1'b1, 5'd2, 1'b1, 5'd18, 1'b1, 5'd4, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("br_stall", ctrl, C_STALL);
      step();
      bus.ex_branch_taken = 1'b1;
      @(negedge clock);
      expect_eq("br_ctrl", ctrl, C_BRANCH);
      step();
      bus.ex_branch_taken = 1'b0;
      // ADD X8,X4,X4: the discarded SUB must not have entered the shadow
      drive_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0);
      @(negedge clock);
      expect_eq("br_discard", ctrl, C_ISSUE);
`ifdef HAZARD_FWD_EN
      expect_eq("br_cnt", bus.stall_count, 2);
`else
      expect_eq("br_cnt", bus.stall_count, 3);
`endif
      step();
      idle_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
